// File: rtl/lock_pkg.sv
// Shared constants for the pushbutton lock timing: channel indices,
// channel state encoding and default channel durations in base ticks.
package lock_pkg;

  localparam int unsigned CH_DEBOUNCE = 0;
  localparam int unsigned CH_TIMEOUT  = 1;
  localparam int unsigned CH_LOCKOUT  = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int unsigned DEBOUNCE_TICKS = 20;
  localparam int unsigned TIMEOUT_TICKS  = 5000;
  localparam int unsigned LOCKOUT_TICKS  = 30000;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel driven by the shared base tick.
// Cancel beats start, start beats a pending timeout.
module timer_channel
  import lock_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          start,
  input  logic          cancel,
  input  logic [TW-1:0] load_val,
  output logic          busy,
  output logic          expire
);

  localparam logic [TW-1:0] CNT_ZERO = TW'(0);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  logic          r_state;
  logic [TW-1:0] r_cnt;
  logic          r_expire;

  // Channel state, countdown and registered expire pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_expire <= 1'b0;
    end else if (cancel) begin
      r_state  <= ST_IDLE;
      r_expire <= 1'b0;
    end else if (start) begin
      r_cnt <= load_val;
      // A zero duration times out immediately without ever showing busy
      if (load_val == CNT_ZERO) begin
        r_state  <= ST_IDLE;
        r_expire <= 1'b1;
      end else begin
        r_state  <= ST_RUN;
        r_expire <= 1'b0;
      end
    end else if ((r_state == ST_RUN) && tick) begin
      if (r_cnt > CNT_ONE) begin
        r_cnt    <= r_cnt - CNT_ONE;
        r_expire <= 1'b0;
      end else begin
        r_state  <= ST_IDLE;
        r_expire <= 1'b1;
      end
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign expire = r_expire;

endmodule

// File: rtl/tick_timer_ctrl.sv
// Shared prescaler, blink generator and NCH countdown channels for the lock.
// Everything runs on clk; the base tick is a one-cycle enable, not a clock.
module tick_timer_ctrl
  import lock_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int NCH         = 3,
  parameter int TW          = 16,
  parameter int BLINK_TICKS = 500
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NCH-1:0]  start,
  input  logic [NCH-1:0]  cancel,
  input  logic [NCH*TW-1:0] load_val,
  output logic            tick,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  expire,
  output logic            blink
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

  logic [PW-1:0] r_pcnt;
  logic [BW-1:0] r_bcnt;
  logic          r_blink;
  logic          w_tick;

  assign w_tick = (r_pcnt == P_LAST);
  assign tick   = w_tick;
  assign blink  = r_blink;

  // Free-running prescaler, never touched by channel activity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= PW'(0);
    end else if (r_pcnt == P_LAST) begin
      r_pcnt <= PW'(0);
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  // Blink half-period counter in base ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bcnt  <= BW'(0);
      r_blink <= 1'b0;
    end else if (w_tick) begin
      if (r_bcnt == B_LAST) begin
        r_bcnt  <= BW'(0);
        r_blink <= ~r_blink;
      end else begin
        r_bcnt  <= r_bcnt + BW'(1);
        r_blink <= r_blink;
      end
    end else begin
      r_bcnt  <= r_bcnt;
      r_blink <= r_blink;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_channel #(
      .TW(TW)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (w_tick),
      .start    (start[g]),
      .cancel   (cancel[g]),
      .load_val (load_val[g*TW +: TW]),
      .busy     (busy[g]),
      .expire   (expire[g])
    );
  end

endmodule
